instr_encoder: RTL and testbench

- Assembles 32-bit MIPS-style instruction words from discrete fields (R, I and J formats). This is the inverse of the pipeline's instruction field decode.
- Streams each encoded word, with its sequential word address, to the instruction-memory loader over a valid/ready handshake.
- Used at boot or by the testbench to program the instruction ROM/RAM before the pipeline is released.
- One-stage registered output; an issue counter stops intake once DEPTH words have been issued.

---
 rtl/instr_pkg.sv | 46 ++++
 rtl/instr_encoder_if.sv | 44 ++++
 rtl/instr_pack.sv | 40 ++++
 rtl/instr_encoder.sv | 109 ++++++++++
 tb/tb_instr_encoder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// instr_pkg
//   Shared definitions for MIPS-style instruction words: format codes, field
//   bit positions and the field bundle consumed by the encoder. The pipeline's
//   field decoder slices instructions with the same constants, so encode and
//   decode cannot drift apart.
package instr_pkg;

  localparam int INSTR_W = 32;

  // Format codes carried on in_fmt
  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_J   = 2'b10;
  localparam logic [1:0] FMT_ILL = 2'b11;

  // Field bit positions inside a 32-bit instruction word
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JADDR_HI = 25;
  localparam int JADDR_LO = 0;

  // Discrete fields of one instruction, before packing
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jump;
  } instr_fields_t;

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
//   Field-bundle input handshake, encoded-word output handshake and status
//   signals of the instruction encoder.
//   master : producer of field bundles / consumer of encoded words (loader side)
//   slave  : the encoder itself
//   Signals: clear, in_valid/in_ready, in_fmt, in_opcode, in_rs, in_rt, in_rd,
//            in_shamt, in_function, in_imm, in_jump, out_valid/out_ready,
//            out_instr, out_addr, err_illegal, full.
interface instr_encoder_if #(
  parameter int i_size = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [5:0]        in_opcode;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_function;
  logic [15:0]       in_imm;
  logic [25:0]       in_jump;
  logic              out_valid;
  logic              out_ready;
  logic [i_size-1:0] out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic              full;

  modport master (
    output clear, in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt,
           in_function, in_imm, in_jump, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_illegal, full
  );

  modport slave (
    input  clear, in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt,
           in_function, in_imm, in_jump, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_illegal, full
  );
endinterface

// File: rtl/instr_pack.sv
// instr_pack
//   Purely combinational packer: format code + discrete fields -> 32-bit word.
//   Ports:
//     i_fmt    format code (R/I/J/illegal)
//     i_fields field bundle
//     o_instr  packed instruction; all zeros for the illegal format
module instr_pack
  import instr_pkg::*;
(
  input  logic [1:0]         i_fmt,
  input  instr_fields_t      i_fields,
  output logic [INSTR_W-1:0] o_instr
);

  always_comb begin
    o_instr = '0;
    case (i_fmt)
      FMT_R: begin
        // Opcode stays zero for R format regardless of i_fields.opcode
        o_instr[RS_HI:RS_LO]       = i_fields.rs;
        o_instr[RT_HI:RT_LO]       = i_fields.rt;
        o_instr[RD_HI:RD_LO]       = i_fields.rd;
        o_instr[SHAMT_HI:SHAMT_LO] = i_fields.shamt;
        o_instr[FUNCT_HI:FUNCT_LO] = i_fields.funct;
      end
      FMT_I: begin
        o_instr[OPC_HI:OPC_LO] = i_fields.opcode;
        o_instr[RS_HI:RS_LO]   = i_fields.rs;
        o_instr[RT_HI:RT_LO]   = i_fields.rt;
        o_instr[IMM_HI:IMM_LO] = i_fields.imm;
      end
      FMT_J: begin
        o_instr[OPC_HI:OPC_LO]     = i_fields.opcode;
        o_instr[JADDR_HI:JADDR_LO] = i_fields.jump;
      end
      default: o_instr = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes R/I/J field bundles into 32-bit instruction words and streams them,
//   with sequential word addresses, to the instruction-memory loader. Intake
//   stops once DEPTH words have been issued; the block then sits in DONE with
//   full=1 until clear or reset.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  instr_encoder_if.slave: clear, input bundle handshake, output word
//          handshake (out_instr/out_addr), err_illegal pulse, full flag
module instr_encoder
  import instr_pkg::*;
#(
  parameter int i_size = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  localparam logic [0:0]      ST_LOAD = 1'b0;
  localparam logic [0:0]      ST_DONE = 1'b1;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

  logic [0:0]        r_state;
  logic [ADDR_W:0]   r_issue_cnt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_out_valid;
  logic [i_size-1:0] r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_err_illegal;

  instr_fields_t     w_fields;
  logic [INSTR_W-1:0] w_instr;
  logic              w_ready;
  logic              w_accept;
  logic              w_legal;
  logic              w_illegal;
  logic              w_out_hs;

  always_comb begin
    w_fields        = '0;
    w_fields.opcode = bus.in_opcode;
    w_fields.rs     = bus.in_rs;
    w_fields.rt     = bus.in_rt;
    w_fields.rd     = bus.in_rd;
    w_fields.shamt  = bus.in_shamt;
    w_fields.funct  = bus.in_function;
    w_fields.imm    = bus.in_imm;
    w_fields.jump   = bus.in_jump;
  end

  instr_pack u_pack (
    .i_fmt    (bus.in_fmt),
    .i_fields (w_fields),
    .o_instr  (w_instr)
  );

  // Ready passes out_ready straight through so a draining word can be replaced
  // in the same cycle; clear blocks intake so a concurrent bundle is kept.
  assign w_ready   = (r_state == ST_LOAD) && (r_issue_cnt < CNT_MAX) &&
                     (!r_out_valid || bus.out_ready) && !bus.clear;
  assign w_accept  = bus.in_valid && w_ready;
  assign w_legal   = w_accept && (bus.in_fmt != FMT_ILL);
  assign w_illegal = w_accept && (bus.in_fmt == FMT_ILL);
  assign w_out_hs  = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_LOAD;
      r_issue_cnt   <= '0;
      r_wr_ptr      <= '0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_addr    <= '0;
      r_err_illegal <= 1'b0;
    end else if (bus.clear) begin
      r_state       <= ST_LOAD;
      r_issue_cnt   <= '0;
      r_wr_ptr      <= '0;
      r_out_valid   <= 1'b0;
      r_err_illegal <= 1'b0;
    end else begin
      r_err_illegal <= w_illegal;
      if (w_legal) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_instr;
        r_out_addr  <= r_wr_ptr;
        r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
        r_issue_cnt <= r_issue_cnt + (ADDR_W + 1)'(1);
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      // The final word leaving the output register completes the load
      if ((r_state == ST_LOAD) && w_out_hs && (r_issue_cnt == CNT_MAX))
        r_state <= ST_DONE;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_instr   = r_out_instr;
  assign bus.out_addr    = r_out_addr;
  assign bus.err_illegal = r_err_illegal;
  assign bus.full        = (r_state == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed bench for instr_encoder: reset values, R/I/J encoding, back-to-back
//   streaming, backpressure hold, illegal-format pulse, fill to DEPTH, clear in
//   DONE and asynchronous reset with a pending word.
module tb_instr_encoder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.i_size(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.i_size(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic [1:0] fmt, input logic [5:0] opc, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                     input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] jmp);
    bus.in_valid    = 1'b1;
    bus.in_fmt      = fmt;
    bus.in_opcode   = opc;
    bus.in_rs       = rs;
    bus.in_rt       = rt;
    bus.in_rd       = rd;
    bus.in_shamt    = sh;
    bus.in_function = fn;
    bus.in_imm      = imm;
    bus.in_jump     = jmp;
  endtask

  task automatic put_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sh, input logic [5:0] fn, input logic [5:0] opc);
    put(2'b00, opc, rs, rt, rd, sh, fn, 16'h0, 26'h0);
  endtask

  task automatic put_i(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [15:0] imm);
    put(2'b01, opc, rs, rt, 5'd0, 5'd0, 6'd0, imm, 26'h0);
  endtask

  task automatic put_j(input logic [5:0] opc, input logic [25:0] jmp);
    put(2'b10, opc, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, jmp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    bus.clear       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_fmt      = 2'b00;
    bus.in_opcode   = '0;
    bus.in_rs       = '0;
    bus.in_rt       = '0;
    bus.in_rd       = '0;
    bus.in_shamt    = '0;
    bus.in_function = '0;
    bus.in_imm      = '0;
    bus.in_jump     = '0;
    bus.out_ready   = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_instr", 64'(bus.out_instr), 64'd0);
    check_eq("rst_addr",  64'(bus.out_addr),  64'd0);
    check_eq("rst_err",   64'(bus.err_illegal), 64'd0);
    check_eq("rst_full",  64'(bus.full), 64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc();

    // R add with junk opcode, then addi and j back-to-back
    put_r(5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 6'h3F);
    #1 check_eq("r_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    check_eq("r_valid", 64'(bus.out_valid), 64'd1);
    check_eq("r_instr", 64'(bus.out_instr), 64'h012A4020);
    check_eq("r_addr",  64'(bus.out_addr),  64'd0);
    put_i(6'd8, 5'd0, 5'd8, 16'd5);
    #1 check_eq("i_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    check_eq("i_instr", 64'(bus.out_instr), 64'h20080005);
    check_eq("i_addr",  64'(bus.out_addr),  64'd1);
    put_j(6'd2, 26'h10);
    #1 check_eq("j_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    check_eq("j_instr", 64'(bus.out_instr), 64'h08000010);
    check_eq("j_addr",  64'(bus.out_addr),  64'd2);
    bus.in_valid = 1'b0;
    cyc();
    check_eq("j_drain", 64'(bus.out_valid), 64'd0);

    // Backpressure: lw pending, sw waiting
    bus.out_ready = 1'b0;
    put_i(6'h23, 5'd29, 5'd8, 16'h0010);
    cyc();
    check_eq("bp_valid", 64'(bus.out_valid), 64'd1);
    check_eq("bp_instr", 64'(bus.out_instr), 64'h8FA80010);
    check_eq("bp_addr",  64'(bus.out_addr),  64'd3);
    put_i(6'h2B, 5'd29, 5'd9, 16'h0014);
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("bp_hold_ready", 64'(bus.in_ready), 64'd0);
      cyc();
      check_eq("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_hold_instr", 64'(bus.out_instr), 64'h8FA80010);
      check_eq("bp_hold_addr",  64'(bus.out_addr),  64'd3);
    end
    bus.out_ready = 1'b1;
    #1 check_eq("bp_rel_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    check_eq("bp_next_valid", 64'(bus.out_valid), 64'd1);
    check_eq("bp_next_instr", 64'(bus.out_instr), 64'hAFA90014);
    check_eq("bp_next_addr",  64'(bus.out_addr),  64'd4);
    bus.in_valid = 1'b0;
    cyc();
    check_eq("bp_drain", 64'(bus.out_valid), 64'd0);

    // Illegal bundle between two legal words
    put_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h22, 6'h00);
    cyc();
    check_eq("il_a_instr", 64'(bus.out_instr), 64'h00221822);
    check_eq("il_a_addr",  64'(bus.out_addr),  64'd5);
    check_eq("il_a_err",   64'(bus.err_illegal), 64'd0);
    put(2'b11, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
    #1 check_eq("il_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    check_eq("il_err",   64'(bus.err_illegal), 64'd1);
    check_eq("il_valid", 64'(bus.out_valid), 64'd0);
    check_eq("il_full",  64'(bus.full), 64'd0);
    put_j(6'd3, 26'h3FFFFFF);
    cyc();
    check_eq("il_b_err",   64'(bus.err_illegal), 64'd0);
    check_eq("il_b_valid", 64'(bus.out_valid), 64'd1);
    check_eq("il_b_instr", 64'(bus.out_instr), 64'h0FFFFFFF);
    check_eq("il_b_addr",  64'(bus.out_addr),  64'd6);

    // Fill the remaining addresses 7..15
    for (int i = 7; i < DEPTH; i++) begin
      put_j(6'd2, 26'(i));
      #1 check_eq("fill_ready", 64'(bus.in_ready), 64'd1);
      cyc();
      check_eq("fill_instr", 64'(bus.out_instr), 64'h08000000 | 64'(i));
      check_eq("fill_addr",  64'(bus.out_addr),  64'(i));
    end
    put_j(6'd2, 26'h2A);
    #1 check_eq("fill_last_ready", 64'(bus.in_ready), 64'd0);
    check_eq("fill_last_full", 64'(bus.full), 64'd0);
    cyc();
    check_eq("done_full",  64'(bus.full), 64'd1);
    check_eq("done_ready", 64'(bus.in_ready), 64'd0);
    check_eq("done_valid", 64'(bus.out_valid), 64'd0);
    cyc();
    check_eq("done_no17_valid", 64'(bus.out_valid), 64'd0);
    check_eq("done_no17_full",  64'(bus.full), 64'd1);

    // Clear in DONE with a bundle offered
    bus.clear = 1'b1;
    #1 check_eq("clr_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    bus.clear = 1'b0;
    check_eq("clr_full",  64'(bus.full), 64'd0);
    check_eq("clr_valid", 64'(bus.out_valid), 64'd0);
    #1 check_eq("clr_after_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    check_eq("clr_next_valid", 64'(bus.out_valid), 64'd1);
    check_eq("clr_next_instr", 64'(bus.out_instr), 64'h0800002A);
    check_eq("clr_next_addr",  64'(bus.out_addr),  64'd0);

    // Asynchronous reset discards a pending word
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1 check_eq("arst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("arst_instr", 64'(bus.out_instr), 64'd0);
    rst_n = 1'b1;
    cyc();
    check_eq("arst_after_valid", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
